// File: rtl/instr_encoder_if.sv
// Request/IMEM-write bundle between a program loader and instr_encoder.
// master = the loader side driving requests; slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
);
  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_op;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [31:0]       i_imm;
  logic              i_addr_load;
  logic [ADDR_W-1:0] i_addr_val;
  logic              i_err_clr;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic [ADDR_W-1:0] o_err_addr;
  logic [CNT_W-1:0]  o_count;

  modport master (
    output i_valid, i_op, i_rd, i_rs1, i_rs2, i_imm, i_addr_load, i_addr_val, i_err_clr,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_err, o_err_code, o_err_addr, o_count
  );

  modport slave (
    input  i_valid, i_op, i_rd, i_rs1, i_rs2, i_imm, i_addr_load, i_addr_val, i_err_clr,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_err, o_err_code, o_err_addr, o_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I encoder filling IMEM: accept at edge N -> write strobe after edge N+2.
// Ready only in RUN; a rejected request parks the block in ERR until i_err_clr.
module instr_encoder #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input logic            i_clk,
  input logic            i_reset,
  instr_encoder_if.slave bus
);
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ERR = 1'b1;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_SH = 3'd1;
  localparam logic [2:0] FMT_I  = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_U  = 3'd6;
  localparam logic [2:0] FMT_X  = 3'd7;

  typedef struct packed {
    logic [2:0] fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;   // funct7 bit 5 (SUB/SRA/SRAI)
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t r;
    r = '{FMT_X, 7'd0, 3'd0, 1'b0};
    case (op)
      6'd0:  r = '{FMT_R,  7'b0110011, 3'd0, 1'b0};
      6'd1:  r = '{FMT_R,  7'b0110011, 3'd0, 1'b1};
      6'd2:  r = '{FMT_R,  7'b0110011, 3'd1, 1'b0};
      6'd3:  r = '{FMT_R,  7'b0110011, 3'd2, 1'b0};
      6'd4:  r = '{FMT_R,  7'b0110011, 3'd3, 1'b0};
      6'd5:  r = '{FMT_R,  7'b0110011, 3'd4, 1'b0};
      6'd6:  r = '{FMT_R,  7'b0110011, 3'd5, 1'b0};
      6'd7:  r = '{FMT_R,  7'b0110011, 3'd5, 1'b1};
      6'd8:  r = '{FMT_R,  7'b0110011, 3'd6, 1'b0};
      6'd9:  r = '{FMT_R,  7'b0110011, 3'd7, 1'b0};
      6'd10: r = '{FMT_I,  7'b0010011, 3'd0, 1'b0};
      6'd11: r = '{FMT_I,  7'b0010011, 3'd2, 1'b0};
      6'd12: r = '{FMT_I,  7'b0010011, 3'd3, 1'b0};
      6'd13: r = '{FMT_I,  7'b0010011, 3'd4, 1'b0};
      6'd14: r = '{FMT_I,  7'b0010011, 3'd6, 1'b0};
      6'd15: r = '{FMT_I,  7'b0010011, 3'd7, 1'b0};
      6'd16: r = '{FMT_SH, 7'b0010011, 3'd1, 1'b0};
      6'd17: r = '{FMT_SH, 7'b0010011, 3'd5, 1'b0};
      6'd18: r = '{FMT_SH, 7'b0010011, 3'd5, 1'b1};
      6'd19: r = '{FMT_I,  7'b0000011, 3'd0, 1'b0};
      6'd20: r = '{FMT_I,  7'b0000011, 3'd1, 1'b0};
      6'd21: r = '{FMT_I,  7'b0000011, 3'd2, 1'b0};
      6'd22: r = '{FMT_I,  7'b0000011, 3'd4, 1'b0};
      6'd23: r = '{FMT_I,  7'b0000011, 3'd5, 1'b0};
      6'd24: r = '{FMT_S,  7'b0100011, 3'd0, 1'b0};
      6'd25: r = '{FMT_S,  7'b0100011, 3'd1, 1'b0};
      6'd26: r = '{FMT_S,  7'b0100011, 3'd2, 1'b0};
      6'd27: r = '{FMT_B,  7'b1100011, 3'd0, 1'b0};
      6'd28: r = '{FMT_B,  7'b1100011, 3'd1, 1'b0};
      6'd29: r = '{FMT_B,  7'b1100011, 3'd4, 1'b0};
      6'd30: r = '{FMT_B,  7'b1100011, 3'd5, 1'b0};
      6'd31: r = '{FMT_B,  7'b1100011, 3'd6, 1'b0};
      6'd32: r = '{FMT_B,  7'b1100011, 3'd7, 1'b0};
      6'd33: r = '{FMT_J,  7'b1101111, 3'd0, 1'b0};
      6'd34: r = '{FMT_I,  7'b1100111, 3'd0, 1'b0};
      6'd35: r = '{FMT_U,  7'b0110111, 3'd0, 1'b0};
      6'd36: r = '{FMT_U,  7'b0010111, 3'd0, 1'b0};
      default: r = '{FMT_X, 7'd0, 3'd0, 1'b0};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] op_fmt(input logic [5:0] op);
    op_info_t r;
    r = decode_op(op);
    return r.fmt;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              a_vld_q;
  logic [5:0]        a_op_q;
  logic [4:0]        a_rd_q, a_rs1_q, a_rs2_q;
  logic [31:0]       a_imm_q;
  logic [ADDR_W-1:0] a_addr_q;

  logic              b_vld_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic [31:0]       b_data_q, b_data_d;

  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              accept, acc_ok;
  logic [1:0]        chk_code;
  logic signed [31:0] imm_s;
  op_info_t          a_info;

  assign accept   = bus.i_valid && (state_q == ST_RUN);
  assign acc_ok   = accept && (chk_code == 2'd0);
  assign cur_addr = bus.i_addr_load ? bus.i_addr_val : addr_q;
  assign addr_d   = cur_addr + ADDR_W'(acc_ok);
  assign imm_s    = $signed(bus.i_imm);

  // Illegal op wins over range, range wins over alignment.
  always_comb begin
    chk_code = 2'd0;
    case (op_fmt(bus.i_op))
      FMT_X:  chk_code = 2'd1;
      FMT_SH: if (bus.i_imm[31:5] != 27'd0) chk_code = 2'd2;
      FMT_I, FMT_S:
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) chk_code = 2'd2;
      FMT_B:
        if (imm_s < -32'sd4096 || imm_s > 32'sd4094) chk_code = 2'd2;
        else if (bus.i_imm[0]) chk_code = 2'd3;
      FMT_J:
        if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) chk_code = 2'd2;
        else if (bus.i_imm[0]) chk_code = 2'd3;
      FMT_U:  if (bus.i_imm[11:0] != 12'd0) chk_code = 2'd2;
      default: chk_code = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (state_q == ST_RUN) begin
      if (accept && chk_code != 2'd0) begin
        state_d    = ST_ERR;
        err_code_d = chk_code;
        err_addr_d = cur_addr;
      end
    end else if (bus.i_err_clr) begin
      state_d    = ST_RUN;
      err_code_d = 2'd0;
      err_addr_d = '0;
    end
  end

  assign count_d = (wr_vld_q && count_q != {CNT_W{1'b1}}) ? count_q + CNT_W'(1) : count_q;

  always_comb begin
    a_info = decode_op(a_op_q);
    case (a_info.fmt)
      FMT_R:  b_data_d = {1'b0, a_info.alt, 5'd0, a_rs2_q, a_rs1_q, a_info.f3, a_rd_q, a_info.opc};
      FMT_SH: b_data_d = {1'b0, a_info.alt, 5'd0, a_imm_q[4:0], a_rs1_q, a_info.f3, a_rd_q, a_info.opc};
      FMT_I:  b_data_d = {a_imm_q[11:0], a_rs1_q, a_info.f3, a_rd_q, a_info.opc};
      FMT_S:  b_data_d = {a_imm_q[11:5], a_rs2_q, a_rs1_q, a_info.f3, a_imm_q[4:0], a_info.opc};
      FMT_B:  b_data_d = {a_imm_q[12], a_imm_q[10:5], a_rs2_q, a_rs1_q, a_info.f3,
                          a_imm_q[4:1], a_imm_q[11], a_info.opc};
      FMT_J:  b_data_d = {a_imm_q[20], a_imm_q[10:1], a_imm_q[11], a_imm_q[19:12], a_rd_q, a_info.opc};
      FMT_U:  b_data_d = {a_imm_q[31:12], a_rd_q, a_info.opc};
      default: b_data_d = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      addr_q     <= '0;
      count_q    <= '0;
      err_code_q <= 2'd0;
      err_addr_q <= '0;
      a_vld_q    <= 1'b0;
      a_op_q     <= 6'd0;
      a_rd_q     <= 5'd0;
      a_rs1_q    <= 5'd0;
      a_rs2_q    <= 5'd0;
      a_imm_q    <= 32'd0;
      a_addr_q   <= '0;
      b_vld_q    <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= 32'd0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
      a_vld_q    <= acc_ok;
      if (acc_ok) begin
        a_op_q   <= bus.i_op;
        a_rd_q   <= bus.i_rd;
        a_rs1_q  <= bus.i_rs1;
        a_rs2_q  <= bus.i_rs2;
        a_imm_q  <= bus.i_imm;
        a_addr_q <= cur_addr;
      end
      b_vld_q    <= a_vld_q;
      b_addr_q   <= a_addr_q;
      b_data_q   <= b_data_d;
      wr_vld_q   <= b_vld_q;
      wr_addr_q  <= b_addr_q;
      wr_data_q  <= b_data_q;
    end
  end

  assign bus.o_ready    = (state_q == ST_RUN);
  assign bus.o_err      = (state_q == ST_ERR);
  assign bus.o_err_code = err_code_q;
  assign bus.o_err_addr = err_addr_q;
  assign bus.o_wr_en    = wr_vld_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign bus.o_count    = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: scoreboard of expected IMEM writes (address, word, cycle).
module tb_instr_encoder;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_count = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus.o_wr_en !== 1'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: wr_en=%b addr=%0d data=%h at cyc %0d, required no write",
                 bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.o_wr_addr !== e.addr || bus.o_wr_data !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   bus.o_wr_addr, bus.o_wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic ld,
                       input logic [ADDR_W-1:0] lval, input logic expect_wr,
                       input logic [ADDR_W-1:0] eaddr, input logic [31:0] edata);
    exp_t e;
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_op        = op;
    bus.i_rd        = rd;
    bus.i_rs1       = rs1;
    bus.i_rs2       = rs2;
    bus.i_imm       = imm;
    bus.i_addr_load = ld;
    bus.i_addr_val  = lval;
    if (expect_wr) begin
      e.addr = eaddr;
      e.data = edata;
      e.cyc  = cyc + 3;
      sb.push_back(e);
      exp_count++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_valid     = 1'b0;
    bus.i_addr_load = 1'b0;
    bus.i_err_clr   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.i_valid   = 1'b0;
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
  endtask

  // Waits for the scoreboard to empty, then one more cycle so o_count settles.
  task automatic drain(output bit ok);
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    ok = (sb.size() == 0);
    if (!ok) sb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.o_ready !== 1'b1 || bus.o_wr_en !== 1'b0 || bus.o_err !== 1'b0 ||
        bus.o_err_code !== 2'd0 || bus.o_err_addr !== '0 || bus.o_count !== '0 ||
        bus.o_wr_addr !== '0 || bus.o_wr_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: ready=%b wr_en=%b err=%b code=%0d eaddr=%0d count=%0d, required 1,0,0,0,0,0",
               bus.o_ready, bus.o_wr_en, bus.o_err, bus.o_err_code, bus.o_err_addr, bus.o_count);
    end
  endtask

  task automatic test_single_add();
    bit ok;
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0, 1'b1, 11'd0, 32'h002081B3);
    idle();
    drain(ok);
    n_cmp++;
    if (!ok || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL single_add: drained=%b count=%0d, required drained=1 count=%0d", ok, bus.o_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    drive(6'd10, 5'd1, 5'd0, 5'd9,  -32'sd1,        1'b1, 11'd0, 1'b1, 11'd0, 32'hFFF00093);
    drive(6'd18, 5'd4, 5'd4, 5'd9,  32'd3,          1'b0, '0,    1'b1, 11'd1, 32'h40325213);
    drive(6'd26, 5'd31, 5'd1, 5'd2, 32'd8,          1'b0, '0,    1'b1, 11'd2, 32'h0020A423);
    drive(6'd27, 5'd17, 5'd1, 5'd2, -32'sd4,        1'b0, '0,    1'b1, 11'd3, 32'hFE208EE3);
    drive(6'd35, 5'd5, 5'd31, 5'd31, 32'h12345000,  1'b0, '0,    1'b1, 11'd4, 32'h123452B7);
    idle();
    drain(ok);
    n_cmp++;
    if (!ok || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL back_to_back: drained=%b count=%0d, required drained=1 count=%0d", ok, bus.o_count, exp_count);
    end
  endtask

  task automatic test_error_range();
    bit ok;
    drive(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 11'd7, 1'b0, '0, '0);
    idle();
    n_cmp++;
    if (bus.o_ready !== 1'b0 || bus.o_err !== 1'b1 || bus.o_err_code !== 2'd2 || bus.o_err_addr !== 11'd7) begin
      n_bad++;
      $display("FAIL err_range: ready=%b err=%b code=%0d eaddr=%0d, required 0,1,2,7",
               bus.o_ready, bus.o_err, bus.o_err_code, bus.o_err_addr);
    end
    // Requests offered while in ERR must be ignored.
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0, 1'b0, '0, '0);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0, 1'b0, '0, '0);
    idle();
    repeat (3) idle();
    n_cmp++;
    if (bus.o_err !== 1'b1 || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL err_hold: err=%b count=%0d, required 1 and %0d", bus.o_err, bus.o_count, exp_count);
    end
    pulse_clr();
    n_cmp++;
    if (bus.o_ready !== 1'b1 || bus.o_err !== 1'b0 || bus.o_err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL err_clear: ready=%b err=%b code=%0d, required 1,0,0", bus.o_ready, bus.o_err, bus.o_err_code);
    end
    drive(6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, '0, 1'b1, 11'd7, 32'h00500093);
    idle();
    drain(ok);
    n_cmp++;
    if (!ok || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL after_clear: drained=%b count=%0d, required drained=1 count=%0d", ok, bus.o_count, exp_count);
    end
  endtask

  task automatic test_error_codes();
    vec_t v[$];
    v.push_back('{6'd40, 5'd1, 5'd1, 5'd1, 32'd0,          32'd1});
    v.push_back('{6'd37, 5'd1, 5'd1, 5'd1, 32'h7FFFFFFF,   32'd1});
    v.push_back('{6'd63, 5'd1, 5'd1, 5'd1, 32'd0,          32'd1});
    v.push_back('{6'd10, 5'd1, 5'd1, 5'd1, 32'd2048,       32'd2});
    v.push_back('{6'd26, 5'd1, 5'd1, 5'd1, -32'sd2049,     32'd2});
    v.push_back('{6'd34, 5'd1, 5'd1, 5'd1, 32'd2048,       32'd2});
    v.push_back('{6'd16, 5'd1, 5'd1, 5'd1, 32'd32,         32'd2});
    v.push_back('{6'd18, 5'd1, 5'd1, 5'd1, -32'sd1,        32'd2});
    v.push_back('{6'd27, 5'd1, 5'd1, 5'd2, 32'd5,          32'd3});
    v.push_back('{6'd27, 5'd1, 5'd1, 5'd2, 32'd4095,       32'd2});
    v.push_back('{6'd27, 5'd1, 5'd1, 5'd2, -32'sd4098,     32'd2});
    v.push_back('{6'd33, 5'd1, 5'd1, 5'd1, 32'd3,          32'd3});
    v.push_back('{6'd33, 5'd1, 5'd1, 5'd1, 32'd1048576,    32'd2});
    v.push_back('{6'd35, 5'd1, 5'd1, 5'd1, 32'h12345001,   32'd2});
    foreach (v[i]) begin
      drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, (i == 0), 11'd200, 1'b0, '0, '0);
      idle();
      n_cmp++;
      if (bus.o_err !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_err_code !== v[i].word[1:0] ||
          bus.o_err_addr !== 11'd200) begin
        n_bad++;
        $display("FAIL err_code[%0d] op=%0d imm=%h: err=%b ready=%b code=%0d eaddr=%0d, required 1,0,%0d,200",
                 i, v[i].op, v[i].imm, bus.o_err, bus.o_ready, bus.o_err_code, bus.o_err_addr, v[i].word[1:0]);
      end
      pulse_clr();
    end
  endtask

  task automatic test_boundaries();
    vec_t v[$];
    bit   ok;
    v.push_back('{6'd10, 5'd1, 5'd0, 5'd9,  -32'sd2048,     32'h80000093});
    v.push_back('{6'd27, 5'd9, 5'd1, 5'd2,  32'd4094,       32'h7E208FE3});
    v.push_back('{6'd27, 5'd9, 5'd1, 5'd2,  -32'sd4096,     32'h80208063});
    v.push_back('{6'd27, 5'd0, 5'd1, 5'd2,  32'd6,          32'h00208363});
    v.push_back('{6'd33, 5'd1, 5'd7, 5'd7,  32'd2048,       32'h001000EF});
    v.push_back('{6'd33, 5'd1, 5'd0, 5'd0,  -32'sd1048576,  32'h800000EF});
    v.push_back('{6'd33, 5'd1, 5'd0, 5'd0,  32'd1048574,    32'h7FFFF0EF});
    v.push_back('{6'd16, 5'd4, 5'd4, 5'd3,  32'd31,         32'h01F21213});
    v.push_back('{6'd21, 5'd5, 5'd1, 5'd6,  -32'sd4,        32'hFFC0A283});
    v.push_back('{6'd36, 5'd7, 5'd3, 5'd3,  32'hABCDE000,   32'hABCDE397});
    v.push_back('{6'd1,  5'd3, 5'd1, 5'd2,  32'hFFFFFFFF,   32'h402081B3});
    foreach (v[i])
      drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, 1'b0, '0, 1'b1,
            ADDR_W'(200 + i), v[i].word);
    idle();
    drain(ok);
    n_cmp++;
    if (!ok || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL boundaries: drained=%b count=%0d, required drained=1 count=%0d", ok, bus.o_count, exp_count);
    end
  endtask

  task automatic test_addr_load();
    bit ok;
    @(negedge clk);
    bus.i_valid     = 1'b0;
    bus.i_addr_load = 1'b1;
    bus.i_addr_val  = 11'd50;
    idle();
    pulse_clr();
    n_cmp++;
    if (bus.o_ready !== 1'b1 || bus.o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_in_run: ready=%b err=%b, required 1,0", bus.o_ready, bus.o_err);
    end
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0,       1'b1, 11'd50,   32'h002081B3);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 11'd2047, 1'b1, 11'd2047, 32'h002081B3);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0,       1'b1, 11'd0,    32'h002081B3);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 11'd100,  1'b1, 11'd100,  32'h002081B3);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0,       1'b1, 11'd101,  32'h002081B3);
    idle();
    drain(ok);
    n_cmp++;
    if (!ok || bus.o_count !== CNT_W'(exp_count)) begin
      n_bad++;
      $display("FAIL addr_load: drained=%b count=%0d, required drained=1 count=%0d", ok, bus.o_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0, 1'b0, '0, '0);
    drive(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.o_wr_en !== 1'b0 || bus.o_count !== '0 || bus.o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: wr_en=%b count=%0d ready=%b, required 0,0,1", bus.o_wr_en, bus.o_count, bus.o_ready);
    end
    repeat (6) idle();
    n_cmp++;
    if (bus.o_count !== '0 || bus.o_ready !== 1'b1 || bus.o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flush: count=%0d ready=%b err=%b, required 0,1,0", bus.o_count, bus.o_ready, bus.o_err);
    end
  endtask

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_op        = 6'd0;
    bus.i_rd        = 5'd0;
    bus.i_rs1       = 5'd0;
    bus.i_rs2       = 5'd0;
    bus.i_imm       = 32'd0;
    bus.i_addr_load = 1'b0;
    bus.i_addr_val  = '0;
    bus.i_err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    test_reset();
    test_single_add();
    test_back_to_back();
    test_error_range();
    test_error_codes();
    test_boundaries();
    test_addr_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
